alu_frame_controller: RTL and testbench

- Parametrised successor to the UART–ALU glue FSM.
- Assembles multi-byte operand frames from the RX FIFO and presents A, B and opcode atomically to the ALU.
- Captures the ALU result and streams it, byte by byte, into the TX FIFO.
- Adds inter-byte timeout recovery, TX backpressure handling and frame status pulses.
- Sits between the UART RX/TX FIFOs and the combinational ALU.

---
 rtl/alu_frame_controller.sv | 141 ++++++++++++++
 tb/tb_alu_frame_controller.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_frame_controller.sv
// Frame controller between the UART FIFOs and a combinational ALU: collects
// A/B/opcode frames from RX, runs the ALU, and streams the result into TX.
module alu_frame_controller #(
   parameter int DATA_BITS      = 8,
   parameter int OPERAND_WIDTH  = 16,
   parameter int OPCODE_WIDTH   = 6,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic                     i_rxff_empty,
   input  logic [DATA_BITS-1:0]     i_rxff_data,
   output logic                     o_rxff_read,
   input  logic                     i_txff_full,
   output logic                     o_txff_write,
   output logic [DATA_BITS-1:0]     o_txff_data,
   input  logic [OPERAND_WIDTH-1:0] i_result,
   output logic [OPERAND_WIDTH-1:0] o_operand_a,
   output logic [OPERAND_WIDTH-1:0] o_operand_b,
   output logic [OPCODE_WIDTH-1:0]  o_opcode,
   output logic                     o_busy,
   output logic                     o_frame_done,
   output logic                     o_frame_error
);

   localparam int NBYTES      = OPERAND_WIDTH / DATA_BITS;
   localparam int FRAME_BYTES = 2 * NBYTES + 1;
   localparam int IDX_W       = $clog2(FRAME_BYTES);
   localparam int SEND_W      = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int TO_W        = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      COLLECT,
      EXEC,
      SEND
   } state_t;

   state_t                              state;
   logic [IDX_W-1:0]                    byte_idx;
   logic [SEND_W-1:0]                   send_idx;
   logic [TO_W-1:0]                     timeout_count;
   logic [2*NBYTES-1:0][DATA_BITS-1:0]  shadow;
   logic [OPERAND_WIDTH-1:0]            result_reg;

   logic rx_pop;
   logic tx_push;
   logic last_byte;
   logic last_send;
   logic timeout_hit;

   // The reset term keeps the pop strobe low while reset is held, even with
   // a non-empty RX FIFO.
   assign rx_pop      = i_reset && (state == COLLECT) && !i_rxff_empty;
   assign tx_push     = (state == SEND) && !i_txff_full;
   assign last_byte   = (byte_idx == IDX_W'(FRAME_BYTES - 1));
   assign last_send   = (send_idx == SEND_W'(NBYTES - 1));
   assign timeout_hit = (timeout_count == TO_W'(TIMEOUT_CYCLES - 1));

   assign o_rxff_read  = rx_pop;
   assign o_txff_write = tx_push;
   assign o_frame_done = tx_push && last_send;
   assign o_busy       = (state != COLLECT);

   always_comb begin
      o_txff_data = '0;
      for (int i = 0; i < NBYTES; i++) begin
         if (send_idx == SEND_W'(i)) begin
            o_txff_data = result_reg[i*DATA_BITS +: DATA_BITS];
         end
      end
   end

   // Operands and opcode only ever change together on the opcode pop, so the
   // ALU never sees a half-assembled frame.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state         <= COLLECT;
         byte_idx      <= '0;
         send_idx      <= '0;
         timeout_count <= '0;
         shadow        <= '0;
         result_reg    <= '0;
         o_operand_a   <= '0;
         o_operand_b   <= '0;
         o_opcode      <= '0;
         o_frame_error <= 1'b0;
      end else begin
         o_frame_error <= 1'b0;
         case (state)
            COLLECT: begin
               if (rx_pop) begin
                  timeout_count <= '0;
                  for (int i = 0; i < 2*NBYTES; i++) begin
                     if (byte_idx == IDX_W'(i)) begin
                        shadow[i] <= i_rxff_data;
                     end
                  end
                  if (last_byte) begin
                     o_operand_a <= shadow[NBYTES-1:0];
                     o_operand_b <= shadow[2*NBYTES-1:NBYTES];
                     o_opcode    <= i_rxff_data[OPCODE_WIDTH-1:0];
                     byte_idx    <= '0;
                     state       <= EXEC;
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                  end
               end else if (byte_idx != '0) begin
                  if (timeout_hit) begin
                     byte_idx      <= '0;
                     timeout_count <= '0;
                     o_frame_error <= 1'b1;
                  end else begin
                     timeout_count <= timeout_count + 1'b1;
                  end
               end else begin
                  timeout_count <= '0;
               end
            end
            EXEC: begin
               result_reg <= i_result;
               send_idx   <= '0;
               state      <= SEND;
            end
            SEND: begin
               if (tx_push) begin
                  if (last_send) begin
                     send_idx <= '0;
                     state    <= COLLECT;
                  end else begin
                     send_idx <= send_idx + 1'b1;
                  end
               end
            end
            default: begin
               state <= COLLECT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_frame_controller.sv
// Bench for alu_frame_controller: FIFO mocks, a mock ALU, and a queue-based
// frame model compared against the DUT on every falling edge.
module tb_alu_frame_controller;

   localparam int DATA_BITS      = 8;
   localparam int OPERAND_WIDTH  = 16;
   localparam int OPCODE_WIDTH   = 6;
   localparam int TIMEOUT_CYCLES = 16;
   localparam int NBYTES         = 2;
   localparam int FRAME_BYTES    = 5;

   logic                     clock = 1'b0;
   logic                     reset;
   logic                     rxffEmpty;
   logic [DATA_BITS-1:0]     rxffData;
   logic                     rxffRead;
   logic                     txffFull;
   logic                     txffWrite;
   logic [DATA_BITS-1:0]     txffData;
   logic [OPERAND_WIDTH-1:0] aluResult;
   logic [OPERAND_WIDTH-1:0] operandA;
   logic [OPERAND_WIDTH-1:0] operandB;
   logic [OPCODE_WIDTH-1:0]  opcode;
   logic                     busy;
   logic                     frameDone;
   logic                     frameError;

   logic [7:0] rxQ[$];
   logic [7:0] txLog[$];
   logic       doneLog[$];
   int checkCount    = 0;
   int errorCount    = 0;
   int doneCount     = 0;
   int errPulseCount = 0;
   int base;
   int guard;

   // Model state: bytes of the frame in progress, idle count, result bytes
   // still owed to TX, and the operands the ALU should currently see.
   logic [7:0]  modelGot[$];
   logic [7:0]  modelTx[$];
   int          modelIdle    = 0;
   logic        modelExec    = 1'b0;
   logic        modelErr     = 1'b0;
   logic [15:0] modelA       = '0;
   logic [15:0] modelB       = '0;
   logic [5:0]  modelOp      = '0;
   logic        collecting;
   logic        expRead;
   logic        expWrite;
   logic        expDone;
   logic        newErr;
   logic [15:0] modelResult;

   alu_frame_controller #(
      .DATA_BITS      (DATA_BITS),
      .OPERAND_WIDTH  (OPERAND_WIDTH),
      .OPCODE_WIDTH   (OPCODE_WIDTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .i_clock       (clock),
      .i_reset       (reset),
      .i_rxff_empty  (rxffEmpty),
      .i_rxff_data   (rxffData),
      .o_rxff_read   (rxffRead),
      .i_txff_full   (txffFull),
      .o_txff_write  (txffWrite),
      .o_txff_data   (txffData),
      .i_result      (aluResult),
      .o_operand_a   (operandA),
      .o_operand_b   (operandB),
      .o_opcode      (opcode),
      .o_busy        (busy),
      .o_frame_done  (frameDone),
      .o_frame_error (frameError)
   );

   always #5 clock = ~clock;

   function automatic logic [15:0] aluRef(input logic [15:0] a, input logic [15:0] b,
                                          input logic [5:0] op);
      return (op == 6'h20) ? a + b : a - b;
   endfunction

   assign aluResult = aluRef(operandA, operandB, opcode);

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic refreshRx();
      rxffEmpty = (rxQ.size() == 0);
      rxffData  = rxffEmpty ? 8'h00 : rxQ[0];
   endtask

   task automatic pushByte(input logic [7:0] b);
      rxQ.push_back(b);
      refreshRx();
   endtask

   task automatic pushFrame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4);
      pushByte(b0);
      pushByte(b1);
      pushByte(b2);
      pushByte(b3);
      pushByte(b4);
   endtask

   // One clock per iteration: strobes are sampled on the falling edge, and the
   // FIFO mocks act on them just after the following rising edge.
   task automatic applyStimulus(input int nCycles);
      logic rd, wr, dn;
      logic [7:0] wd;
      for (int i = 0; i < nCycles; i++) begin
         @(negedge clock);
         rd = rxffRead;
         wr = txffWrite;
         wd = txffData;
         dn = frameDone;
         @(posedge clock);
         #1;
         if (rd && rxQ.size() > 0) rxQ.delete(0);
         if (wr) begin
            txLog.push_back(wd);
            doneLog.push_back(dn);
         end
         refreshRx();
      end
   endtask

   // Compare the DUT against the model, then advance the model across the
   // coming rising edge using the inputs that are stable until then.
   always @(negedge clock) begin
      if (!reset) begin
         checkOutput("rst_rxff_read", rxffRead, 0);
         checkOutput("rst_txff_write", txffWrite, 0);
         checkOutput("rst_frame_done", frameDone, 0);
         checkOutput("rst_frame_error", frameError, 0);
         checkOutput("rst_busy", busy, 0);
         checkOutput("rst_operand_a", operandA, 0);
         checkOutput("rst_operand_b", operandB, 0);
         checkOutput("rst_opcode", opcode, 0);
         modelGot.delete();
         modelTx.delete();
         modelIdle = 0;
         modelExec = 1'b0;
         modelErr  = 1'b0;
         modelA    = '0;
         modelB    = '0;
         modelOp   = '0;
      end else begin
         if (frameDone) doneCount++;
         if (frameError) errPulseCount++;
         collecting = !modelExec && (modelTx.size() == 0);
         expRead    = collecting && !rxffEmpty;
         expWrite   = (modelTx.size() > 0) && !txffFull;
         expDone    = expWrite && (modelTx.size() == 1);
         checkOutput("rxff_read", rxffRead, expRead);
         checkOutput("txff_write", txffWrite, expWrite);
         checkOutput("frame_done", frameDone, expDone);
         checkOutput("frame_error", frameError, modelErr);
         checkOutput("busy", busy, !collecting);
         checkOutput("operand_a", operandA, modelA);
         checkOutput("operand_b", operandB, modelB);
         checkOutput("opcode", opcode, modelOp);
         if (modelTx.size() > 0) checkOutput("txff_data", txffData, modelTx[0]);

         newErr = 1'b0;
         if (modelExec) begin
            modelResult = aluRef(modelA, modelB, modelOp);
            for (int i = 0; i < NBYTES; i++) modelTx.push_back(modelResult[8*i +: 8]);
            modelExec = 1'b0;
         end else if (modelTx.size() > 0) begin
            if (expWrite) modelTx.delete(0);
         end else if (expRead) begin
            modelGot.push_back(rxffData);
            modelIdle = 0;
            if (modelGot.size() == FRAME_BYTES) begin
               modelA    = {modelGot[1], modelGot[0]};
               modelB    = {modelGot[3], modelGot[2]};
               modelOp   = modelGot[4][5:0];
               modelExec = 1'b1;
               modelGot.delete();
            end
         end else if (modelGot.size() > 0) begin
            modelIdle++;
            if (modelIdle == TIMEOUT_CYCLES) begin
               modelGot.delete();
               modelIdle = 0;
               newErr    = 1'b1;
            end
         end else begin
            modelIdle = 0;
         end
         modelErr = newErr;
      end
   end

   initial begin
      reset    = 1'b0;
      txffFull = 1'b0;
      refreshRx();
      applyStimulus(3);
      checkOutput("reset_operand_a", operandA, 16'h0000);
      checkOutput("reset_opcode", opcode, 6'h00);
      checkOutput("reset_busy", busy, 0);
      reset = 1'b1;
      applyStimulus(2);

      $display("[TB] basic frame");
      pushFrame(8'h34, 8'h12, 8'h78, 8'h56, 8'h20);
      applyStimulus(12);
      checkOutput("t1_operand_a", operandA, 16'h1234);
      checkOutput("t1_operand_b", operandB, 16'h5678);
      checkOutput("t1_opcode", opcode, 6'h20);
      checkOutput("t1_tx_count", txLog.size(), 2);
      if (txLog.size() >= 2) begin
         checkOutput("t1_tx_byte0", txLog[0], 8'hAC);
         checkOutput("t1_tx_byte1", txLog[1], 8'h68);
         checkOutput("t1_done_byte0", doneLog[0], 0);
         checkOutput("t1_done_byte1", doneLog[1], 1);
      end
      checkOutput("t1_done_count", doneCount, 1);

      $display("[TB] backpressure");
      base     = txLog.size();
      txffFull = 1'b1;
      pushFrame(8'h34, 8'h12, 8'h78, 8'h56, 8'h20);
      applyStimulus(9);
      checkOutput("t2_stall_write", txffWrite, 0);
      checkOutput("t2_stall_data", txffData, 8'hAC);
      checkOutput("t2_stall_busy", busy, 1);
      checkOutput("t2_stall_nolog", txLog.size(), base);
      txffFull = 1'b0;
      applyStimulus(6);
      checkOutput("t2_tx_count", txLog.size(), base + 2);
      if (txLog.size() >= base + 2) begin
         checkOutput("t2_tx_byte0", txLog[base], 8'hAC);
         checkOutput("t2_tx_byte1", txLog[base+1], 8'h68);
      end
      checkOutput("t2_done_count", doneCount, 2);

      $display("[TB] timeout");
      pushByte(8'h11);
      pushByte(8'h22);
      applyStimulus(2);
      applyStimulus(15);
      checkOutput("t3_no_early_error", errPulseCount, 0);
      applyStimulus(3);
      checkOutput("t3_error_count", errPulseCount, 1);
      checkOutput("t3_operand_a_kept", operandA, 16'h1234);
      checkOutput("t3_operand_b_kept", operandB, 16'h5678);
      base = txLog.size();
      pushFrame(8'h01, 8'h00, 8'h02, 8'h00, 8'h20);
      applyStimulus(12);
      checkOutput("t3_operand_a", operandA, 16'h0001);
      checkOutput("t3_operand_b", operandB, 16'h0002);
      checkOutput("t3_tx_count", txLog.size(), base + 2);
      if (txLog.size() >= base + 2) begin
         checkOutput("t3_tx_byte0", txLog[base], 8'h03);
         checkOutput("t3_tx_byte1", txLog[base+1], 8'h00);
      end

      $display("[TB] gaps just under the limit");
      base = txLog.size();
      pushByte(8'h05); applyStimulus(1); applyStimulus(15);
      pushByte(8'h01); applyStimulus(1); applyStimulus(15);
      pushByte(8'h03); applyStimulus(1); applyStimulus(15);
      pushByte(8'h00); applyStimulus(1); applyStimulus(15);
      pushByte(8'hE1); applyStimulus(8);
      checkOutput("t4_error_count", errPulseCount, 1);
      checkOutput("t4_operand_a", operandA, 16'h0105);
      checkOutput("t4_operand_b", operandB, 16'h0003);
      checkOutput("t4_opcode", opcode, 6'h21);
      checkOutput("t4_tx_count", txLog.size(), base + 2);
      if (txLog.size() >= base + 2) begin
         checkOutput("t4_tx_byte0", txLog[base], 8'h02);
         checkOutput("t4_tx_byte1", txLog[base+1], 8'h01);
      end

      $display("[TB] back-to-back frames");
      base = txLog.size();
      pushFrame(8'h34, 8'h12, 8'h78, 8'h56, 8'h20);
      pushFrame(8'h10, 8'h00, 8'h03, 8'h00, 8'h01);
      applyStimulus(25);
      checkOutput("t5_tx_count", txLog.size(), base + 4);
      if (txLog.size() >= base + 4) begin
         checkOutput("t5_tx_byte0", txLog[base], 8'hAC);
         checkOutput("t5_tx_byte1", txLog[base+1], 8'h68);
         checkOutput("t5_tx_byte2", txLog[base+2], 8'h0D);
         checkOutput("t5_tx_byte3", txLog[base+3], 8'h00);
      end
      checkOutput("t5_done_count", doneCount, 6);
      checkOutput("t5_operand_a", operandA, 16'h0010);

      $display("[TB] reset during SEND");
      base = txLog.size();
      pushFrame(8'h34, 8'h12, 8'h78, 8'h56, 8'h20);
      guard = 0;
      while (txLog.size() == base && guard < 30) begin
         applyStimulus(1);
         guard++;
      end
      checkOutput("t6_first_byte_seen", txLog.size(), base + 1);
      txffFull = 1'b1;
      applyStimulus(1);
      reset = 1'b0;
      #1;
      checkOutput("t6_async_busy", busy, 0);
      checkOutput("t6_async_write", txffWrite, 0);
      checkOutput("t6_async_operand_a", operandA, 16'h0000);
      checkOutput("t6_async_opcode", opcode, 6'h00);
      applyStimulus(2);
      reset    = 1'b1;
      txffFull = 1'b0;
      applyStimulus(4);
      checkOutput("t6_no_more_writes", txLog.size(), base + 1);

      $display("[TB] reset during COLLECT");
      pushByte(8'h11);
      pushByte(8'h22);
      applyStimulus(3);
      reset = 1'b0;
      #1;
      checkOutput("t6c_async_operand_b", operandB, 16'h0000);
      checkOutput("t6c_async_read", rxffRead, 0);
      applyStimulus(2);
      reset = 1'b1;
      base  = txLog.size();
      pushFrame(8'h01, 8'h00, 8'h02, 8'h00, 8'h20);
      applyStimulus(12);
      checkOutput("t6c_operand_a", operandA, 16'h0001);
      checkOutput("t6c_operand_b", operandB, 16'h0002);
      checkOutput("t6c_tx_count", txLog.size(), base + 2);
      if (txLog.size() >= base + 2) begin
         checkOutput("t6c_tx_byte0", txLog[base], 8'h03);
         checkOutput("t6c_tx_byte1", txLog[base+1], 8'h00);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
